// File: rtl/aes_key_schedule_if.sv
// Purpose : bundle of the AES-128 key schedule command/response signals.
// Signals : start, dec, key_in, rk_next  - driven by the consumer (master)
//           busy, rk_valid, rk_out,
//           rk_idx, rk_last              - driven by the key schedule (slave)
interface aes_key_schedule_if;
    logic         start;
    logic         dec;
    logic [127:0] key_in;
    logic         rk_next;
    logic         busy;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_last;

    modport master (
        output start, dec, key_in, rk_next,
        input  busy, rk_valid, rk_out, rk_idx, rk_last
    );

    modport slave (
        input  start, dec, key_in, rk_next,
        output busy, rk_valid, rk_out, rk_idx, rk_last
    );
endinterface

// File: rtl/aes_key_schedule.sv
// Purpose : iterative AES-128 key expansion (one round key per cycle) into
//           an (NR+1) x 128 round-key store, then serves the round keys in
//           encrypt order (0..NR) or decrypt order (NR..0), wrapping after
//           the last key so the next block reuses the schedule.
// Ports   : clk   - single clock, rising edge
//           rst_n - synchronous reset, active-low
//           bus   - aes_key_schedule_if.slave (start/dec/key_in/rk_next in,
//                   busy/rk_valid/rk_out/rk_idx/rk_last out)
module aes_key_schedule #(
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_key_schedule_if.slave bus
);
    localparam logic [3:0] LAST_IDX  = 4'(NR);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [1:0]   state_reg;
    logic [127:0] prev_reg;     // last key produced; avoids reading the store during expansion
    logic [7:0]   rcon_reg;
    logic [3:0]   cnt_reg;
    logic [3:0]   ptr_reg;
    logic [3:0]   ptr_next;
    logic         dec_reg;
    logic [127:0] rk_out_reg;
    logic [127:0] store [NR+1];

    // Round function on the previous key
    logic [31:0]  w0, w1, w2, w3, rot_word, sub_word, n0, n1, n2, n3;
    logic [127:0] next_key;
    logic [7:0]   rcon_next;

    assign w0       = prev_reg[127:96];
    assign w1       = prev_reg[95:64];
    assign w2       = prev_reg[63:32];
    assign w3       = prev_reg[31:0];
    assign rot_word = {w3[23:0], w3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub
            assign sub_word[gi*8 +: 8] = SBOX[rot_word[gi*8 +: 8]];
        end
    endgenerate

    assign n0        = w0 ^ sub_word ^ {rcon_reg, 24'h0};
    assign n1        = w1 ^ n0;
    assign n2        = w2 ^ n1;
    assign n3        = w3 ^ n2;
    assign next_key  = {n0, n1, n2, n3};
    assign rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

    // Control decode
    logic is_expand, is_ready, start_ok, step_ok, expand_done, rk_load;

    assign is_expand   = (state_reg == ST_EXPAND);
    assign is_ready    = (state_reg == ST_READY);
    assign start_ok    = bus.start && !is_expand;           // start ignored mid-expansion
    assign step_ok     = is_ready && bus.rk_next && !bus.start;  // start beats rk_next
    assign expand_done = is_expand && (cnt_reg == LAST_IDX);
    assign rk_load     = expand_done || step_ok;

    always_comb begin
        ptr_next = ptr_reg;
        if (expand_done) begin
            ptr_next = dec_reg ? LAST_IDX : 4'd0;
        end else if (step_ok) begin
            if (dec_reg)
                ptr_next = (ptr_reg == 4'd0) ? LAST_IDX : ptr_reg - 4'd1;
            else
                ptr_next = (ptr_reg == LAST_IDX) ? 4'd0 : ptr_reg + 4'd1;
        end
    end

    // Single write port into the round-key store
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [127:0] wr_data;

    assign wr_en   = rst_n && (start_ok || is_expand);
    assign wr_addr = start_ok ? 4'd0 : cnt_reg;
    assign wr_data = start_ok ? bus.key_in : next_key;

    always_ff @(posedge clk) begin
        if (wr_en)
            store[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            prev_reg   <= '0;
            rcon_reg   <= '0;
            cnt_reg    <= '0;
            ptr_reg    <= '0;
            dec_reg    <= 1'b0;
            rk_out_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            // Key NR is being written this very edge, so a decrypt schedule
            // takes its first key straight from the round function.
            if (rk_load)
                rk_out_reg <= (expand_done && dec_reg) ? next_key : store[ptr_next];
            if (start_ok) begin
                prev_reg  <= bus.key_in;
                dec_reg   <= bus.dec;
                rcon_reg  <= 8'h01;
                cnt_reg   <= 4'd1;
                state_reg <= ST_EXPAND;
            end else if (is_expand) begin
                prev_reg <= next_key;
                rcon_reg <= rcon_next;
                cnt_reg  <= cnt_reg + 4'd1;
                if (expand_done)
                    state_reg <= ST_READY;
            end
        end
    end

    assign bus.busy     = is_expand;
    assign bus.rk_valid = is_ready;
    assign bus.rk_out   = rk_out_reg;
    assign bus.rk_idx   = ptr_reg;
    assign bus.rk_last  = is_ready && (dec_reg ? (ptr_reg == 4'd0) : (ptr_reg == LAST_IDX));
endmodule

// File: tb/tb_aes_key_schedule.sv
// Purpose : self-checking bench for aes_key_schedule. A transaction-level
//           model (S-box derived from GF(2^8) inversion, word-wise key
//           expansion, expected key position) is compared with the DUT on
//           every falling edge; directed FIPS-197 literals pin the model.
module tb_aes_key_schedule;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_schedule_if bus();

    aes_key_schedule #(.NR(10)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RKA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RKA = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sb [256];
    logic [127:0] m_keys [11];
    int           m_phase = 0;   // 0 idle, 1 expanding, 2 ready
    int           m_wait  = 0;
    int           m_pos   = 0;
    logic         m_dec   = 1'b0;
    logic         m_armed = 1'b0;
    logic         m_zero  = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in, b = b_in, p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_zero = 1'b1; m_armed = 1'b1; m_pos = 0; m_dec = 1'b0;
        end else if (m_phase == 1) begin
            m_wait--;
            if (m_wait == 0) begin
                m_phase = 2;
                m_pos   = m_dec ? 10 : 0;
            end
        end else if (bus.start) begin
            expand_model(bus.key_in);
            m_dec = bus.dec; m_phase = 1; m_wait = 10; m_zero = 1'b0;
        end else if (m_phase == 2 && bus.rk_next) begin
            if (m_dec) m_pos = (m_pos == 0) ? 10 : m_pos - 1;
            else       m_pos = (m_pos == 10) ? 0 : m_pos + 1;
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (m_armed) begin
            chk("busy", 128'(bus.busy), 128'(m_phase == 1));
            chk("rk_valid", 128'(bus.rk_valid), 128'(m_phase == 2));
            if (m_phase == 2) begin
                chk("rk_out", bus.rk_out, m_keys[m_pos]);
                chk("rk_idx", 128'(bus.rk_idx), 128'(m_pos));
                chk("rk_last", 128'(bus.rk_last), 128'(m_dec ? (m_pos == 0) : (m_pos == 10)));
            end
            if (m_zero) begin
                chk("zero rk_out", bus.rk_out, 128'h0);
                chk("zero rk_idx", 128'(bus.rk_idx), 128'h0);
                chk("zero rk_last", 128'(bus.rk_last), 128'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_key(input logic [127:0] k, input logic d);
        bus.key_in = k; bus.dec = d; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic step(input int n);
        bus.rk_next = 1'b1;
        repeat (n) @(negedge clk);
        bus.rk_next = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_last;
        bus.start = 1'b0; bus.dec = 1'b0; bus.key_in = '0; bus.rk_next = 1'b0;
        build_sbox();
        tick(2);
        rst_n = 1'b1;
        chk("reset rk_valid", 128'(bus.rk_valid), 128'h0);
        chk("reset rk_out", bus.rk_out, 128'h0);

        // 1: FIPS key, encrypt order
        start_key(FIPS_KEY, 1'b0);
        tick(9);
        chk("c1 valid before 10", 128'(bus.rk_valid), 128'h0);
        tick(1);
        chk("c1 valid at 10", 128'(bus.rk_valid), 128'h1);
        chk("c1 idx0", bus.rk_out, FIPS_KEY);
        step(1);
        chk("c1 idx1", bus.rk_out, FIPS_RK1);
        step(9);
        chk("c1 idx10", bus.rk_out, FIPS_RKA);
        chk("c1 last", 128'(bus.rk_last), 128'h1);

        // 2: FIPS key, decrypt order
        start_key(FIPS_KEY, 1'b1);
        tick(10);
        chk("c2 first", bus.rk_out, FIPS_RKA);
        chk("c2 first idx", 128'(bus.rk_idx), 128'd10);
        step(10);
        chk("c2 idx0", bus.rk_out, FIPS_KEY);
        chk("c2 last", 128'(bus.rk_last), 128'h1);
        step(1);
        chk("c2 wrap idx", 128'(bus.rk_idx), 128'd10);

        // 3: zero key
        start_key(128'h0, 1'b0);
        tick(10);
        step(1);
        chk("c3 idx1", bus.rk_out, ZERO_RK1);
        step(9);
        chk("c3 idx10", bus.rk_out, ZERO_RKA);

        // 4: start during expansion ignored; start in READY (with rk_next) restarts
        start_key(FIPS_KEY, 1'b0);
        tick(3);
        start_key(128'h00112233445566778899aabbccddeeff, 1'b1);
        tick(6);
        chk("c4 valid", 128'(bus.rk_valid), 128'h1);
        chk("c4 idx0", bus.rk_out, FIPS_KEY);
        step(1);
        chk("c4 idx1", bus.rk_out, FIPS_RK1);
        bus.rk_next = 1'b1;
        start_key(128'h0, 1'b0);
        bus.rk_next = 1'b0;
        chk("c4 restart valid", 128'(bus.rk_valid), 128'h0);
        tick(10);
        step(1);
        chk("c4 zero idx1", bus.rk_out, ZERO_RK1);

        // 5: reset mid-expansion and in READY with rk_next
        start_key(FIPS_KEY, 1'b0);
        tick(4);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("c5 busy after rst", 128'(bus.busy), 128'h0);
        bus.rk_next = 1'b1;
        tick(3);
        bus.rk_next = 1'b0;
        chk("c5 idle rk_idx", 128'(bus.rk_idx), 128'h0);
        start_key(FIPS_KEY, 1'b0);
        tick(10);
        step(2);
        rst_n = 1'b0; bus.rk_next = 1'b1;
        tick(1);
        rst_n = 1'b1; bus.rk_next = 1'b0;
        chk("c5 ready rst valid", 128'(bus.rk_valid), 128'h0);
        chk("c5 ready rst out", bus.rk_out, 128'h0);

        // 6: continuous rk_next for 33 cycles
        start_key(FIPS_KEY, 1'b0);
        tick(10);
        n_last = 0;
        bus.rk_next = 1'b1;
        repeat (33) begin
            @(negedge clk);
            if (bus.rk_last) n_last++;
        end
        bus.rk_next = 1'b0;
        chk("c6 last count", 128'(n_last), 128'd3);
        chk("c6 final idx", 128'(bus.rk_idx), 128'd0);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
